alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single rexta ALU between NUM_REQ requesters (e.g. execute stage, address generation, branch compare).
//  Round-robin grant with a valid/ready handshake per requester; one registered response bus with backpressure.
//  Instantiates alu internally. Supports alu_op_t ops: ADD, SUB, SLT, SLTU, AND, OR, XOR.
// PARAMETERS
//  NUM_REQ   2   number of requesters; legal range 2..4
//  CNT_W     16  width of each wait counter (used only with ALU_ARB_STATS_EN)
// PORTS
//  clk             in   1              single clock; all state updates on rising edge
//  rst             in   1              reset: synchronous, active-high
//  req_valid       in   NUM_REQ        requester i presents an operation
//  req_ready       out  NUM_REQ        one-hot (or zero) grant; op accepted when valid&ready
//  req_op          in   NUM_REQ x alu_op_t   operation per requester
//  req_a           in   NUM_REQ x 32   operand A per requester
//  req_b           in   NUM_REQ x 32   operand B per requester
//  rsp_valid       out  1              response register holds a result
//  rsp_ready       in   1              consumer takes response when valid&ready
//  rsp_id          out  $clog2(NUM_REQ)  index of requester that owns rsp_result
//  rsp_result      out  32             registered ALU result
//  rsp_zero        out  1              registered ALU is_zero
//  stat_wait_cnt   out  NUM_REQ x CNT_W  per-requester stall counters (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rr_ptr=0, counters=0.
//    While rst=1, req_ready=0. A response pending at reset is discarded; no handshake completes during reset.
//  - can_accept = !rsp_valid | rsp_ready (slot empty or draining in the same cycle).
//  - Grant (combinational): if can_accept, search from rr_ptr upward modulo NUM_REQ; the first i with req_valid[i]
//    gets req_ready[i]=1; all others 0. If !can_accept or no valid, req_ready=0.
//  - req_ready never depends on req_ready; it depends on req_valid (same-cycle grant); requesters must not make valid depend on ready.
//  - Requester rules: once valid=1, op/a/b are held stable and valid stays 1 until accepted.
//  - Fire (valid&ready on i): ALU is driven with requester i's op/a/b; next edge: rsp_result<=result,
//    rsp_zero<=is_zero, rsp_id<=i, rsp_valid<=1, rr_ptr<=(i+1) mod NUM_REQ. Latency: accept edge -> rsp_valid next cycle.
//  - No fire: rr_ptr unchanged. rsp_valid&rsp_ready without new fire: rsp_valid<=0; data regs hold their last value.
//  - Simultaneous drain and fire: the new result replaces the old one; rsp_valid stays 1 (full throughput, 1 op/cycle).
//  - rsp_valid=1 & rsp_ready=0: all outputs held; no grant issued.
//  - Arithmetic: 32-bit wrap (ADD 0xFFFFFFFF+1=0, zero=1); SLT signed, SLTU unsigned; unknown op -> result 0, zero=1.
//  - Fairness: a continuously valid requester is granted within NUM_REQ accepting cycles.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined: stat_wait_cnt[i] increments each cycle req_valid[i]&!req_ready[i] (rst=0),
//    saturating at 2^CNT_W-1; cleared only by rst.
//  ALU_ARB_STATS_EN undefined: counters not built; stat_wait_cnt tied to 0; all other behaviour identical.
// TESTING
//  1 Single req: req0 ADD a=5 b=7, rsp_ready=1 -> req_ready[0] same cycle; next cycle rsp_valid=1, result=12, id=0, zero=0.
//  2 Contention: req0 and req1 both valid every cycle, rr_ptr=0 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1, one per cycle.
//  3 Backpressure: rsp_ready=0 with rsp_valid=1 -> req_ready=0 and rsp held for 5 cycles; rsp_ready=1 -> drain + new grant in the same cycle.
//  4 Arithmetic edges: SUB 0-1 -> 0xFFFFFFFF; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; XOR a=a -> 0, zero=1.
//  5 Reset mid-op: rst=1 for one cycle while rsp_valid=1 -> next cycle rsp_valid=0, rsp_result=0, rr_ptr=0 (req0 wins next tie).
//  6 Stats (ALU_ARB_STATS_EN): req1 blocked 3 cycles by req0 + backpressure -> stat_wait_cnt[1]=3; saturation at 0xFFFF holds.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_arbiter_if                                               |
// | Description : Requester/response bundle for alu_arbiter, plus the ALU      |
// |               operation encoding (alu_op_t) shared by both sides.          |
// |   slave  modport (arbiter) : in  req_valid, req_op, req_a, req_b,          |
// |                                  rsp_ready                                 |
// |                              out req_ready, rsp_valid, rsp_id,             |
// |                                  rsp_result, rsp_zero                      |
// |   master modport (clients) : the same signals, opposite directions         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

// Encodings 3'd7 and above are not valid operations; the ALU returns 0 for
// them, so the arbiter needs no special handling for them.
typedef enum logic [2:0] {
  ALU_ADD  = 3'd0,
  ALU_SUB  = 3'd1,
  ALU_SLT  = 3'd2,
  ALU_SLTU = 3'd3,
  ALU_AND  = 3'd4,
  ALU_OR   = 3'd5,
  ALU_XOR  = 3'd6
} alu_op_t;

interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic    [NUM_REQ-1:0]       req_valid;
  logic    [NUM_REQ-1:0]       req_ready;
  alu_op_t [NUM_REQ-1:0]       req_op;
  logic    [NUM_REQ-1:0][31:0] req_a;
  logic    [NUM_REQ-1:0][31:0] req_b;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic    [ID_W-1:0]          rsp_id;
  logic    [31:0]              rsp_result;
  logic                        rsp_zero;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_arbiter                                                  |
// | Description : Round-robin sharing of one 32-bit ALU between NUM_REQ        |
// |               requesters, with a single registered response slot that      |
// |               supports backpressure and one operation per cycle.           |
// |   clk           in   clock, rising edge                                    |
// |   rst           in   synchronous, active-high reset                        |
// |   bus           slave modport of alu_arbiter_if (requests and response)    |
// |   stat_wait_cnt out  per-requester stall counters                          |
// | Config macro: ALU_ARB_STATS_EN builds the saturating stall counters;       |
// |               when it is undefined, stat_wait_cnt is tied to zero.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int NUM_REQ = 2,   // 2..4
  parameter int CNT_W   = 16
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  alu_arbiter_if.slave                        bus,
  output logic [NUM_REQ-1:0][CNT_W-1:0]       stat_wait_cnt
);

  localparam int              ID_W      = $clog2(NUM_REQ);
  localparam logic [ID_W:0]   C_NUM_REQ = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(NUM_REQ - 1);

  logic            rsp_valid_q,  rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q,     rsp_id_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_zero_q,   rsp_zero_d;
  logic [ID_W-1:0] rr_ptr_q,     rr_ptr_d;

  logic               can_accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    sel_id;
  logic               fire;
  logic [ID_W:0]      scan_sum;
  logic [ID_W-1:0]    scan_idx;

  alu_op_t     alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  // Grant: scan from rr_ptr upward (wrapping). The loop runs from the farthest
  // position back to the nearest so the last hit - the closest one to rr_ptr -
  // is the one that remains.
  always_comb begin
    grant      = '0;
    sel_id     = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    can_accept = !rsp_valid_q || bus.rsp_ready;
    if (!rst && can_accept) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (scan_sum >= C_NUM_REQ) begin
          scan_sum = scan_sum - C_NUM_REQ;
        end
        scan_idx = scan_sum[ID_W-1:0];
        if (bus.req_valid[scan_idx]) begin
          grant           = '0;
          grant[scan_idx] = 1'b1;
          sel_id          = scan_idx;
        end
      end
    end
    fire = |grant;
  end

  // The ALU always sees the selected requester; its output is only captured
  // when a handshake completes.
  always_comb begin
    alu_op = bus.req_op[sel_id];
    alu_a  = bus.req_a[sel_id];
    alu_b  = bus.req_b[sel_id];
  end

  alu u_alu (
    .op      (alu_op),
    .a       (alu_a),
    .b       (alu_b),
    .result  (alu_result),
    .is_zero (alu_zero)
  );

  // A new fire overwrites the slot even while it drains, which keeps the
  // throughput at one operation per cycle. A plain drain only clears valid.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rr_ptr_d     = rr_ptr_q;
    if (fire) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = sel_id;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      rr_ptr_d     = (sel_id == C_LAST_ID) ? '0 : sel_id + 1'b1;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // A stall is any cycle a requester is valid but not granted, including
  // cycles lost to response backpressure. Counters saturate.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && !grant[i] && (wait_cnt_q[i] != C_CNT_MAX)) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign stat_wait_cnt = wait_cnt_q;
`else
  assign stat_wait_cnt = '0;
`endif

endmodule

// +----------------------------------------------------------------------------+
// | Module      : alu                                                          |
// | Description : Combinational 32-bit ALU. Invalid operations give 0.         |
// |   op in, a in, b in, result out, is_zero out                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu (
  input  wire alu_op_t     op,
  input  wire logic [31:0] a,
  input  wire logic [31:0] b,
  output logic      [31:0] result,
  output logic             is_zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'b0, (a < b)};
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      default:  result = '0;
    endcase
    is_zero = (result == 32'd0);
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_arbiter                                               |
// | Description : Directed and random checks of alu_arbiter against a          |
// |               behavioural model built from the arbitration rules.          |
// |               Honours ALU_ARB_STATS_EN for the stall counters.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alu_arbiter;

  localparam int NR    = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0][CNT_W-1:0] stat;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(NR)) bus ();

  alu_arbiter #(.NUM_REQ(NR), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .stat_wait_cnt (stat)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_valid;
  int          m_id;
  logic [31:0] m_result;
  bit          m_zero;
  int          m_ptr;
  int          m_cnt [NR];

  logic [NR-1:0] last_ready;
  logic [31:0]   held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      default:  r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Winner = first valid requester at or after the pointer, wrapping; none if
  // the slot cannot take a result or reset is asserted.
  function automatic int ref_grant();
    if (rst || !(!m_valid || bus.rsp_ready)) return -1;
    for (int k = 0; k < NR; k++) begin
      if (bus.req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  // Inputs are set 1 time unit after a rising edge; the grant is checked
  // mid-cycle, registered outputs 1 unit after the next edge.
  task automatic cycle();
    int g;
    logic [NR-1:0] expg;
    logic [32:0] r;
    #4;
    g    = ref_grant();
    expg = '0;
    if (g >= 0) expg[g] = 1'b1;
    last_ready = bus.req_ready;
    chk("req_ready", 32'(last_ready), 32'(expg));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_result = '0; m_zero = 0; m_ptr = 0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i] && g != i && m_cnt[i] < CMAX) m_cnt[i]++;
      end
      if (g >= 0) begin
        r        = ref_alu(bus.req_op[g], bus.req_a[g], bus.req_b[g]);
        m_valid  = 1;
        m_id     = g;
        m_result = r[31:0];
        m_zero   = r[32];
        m_ptr    = (g + 1) % NR;
      end else if (m_valid && bus.rsp_ready) begin
        m_valid = 0;
      end
    end
    #1;
    chk("rsp_valid",  32'(bus.rsp_valid), 32'(m_valid));
    chk("rsp_id",     32'(bus.rsp_id),    32'(m_id));
    chk("rsp_result", bus.rsp_result,     m_result);
    chk("rsp_zero",   32'(bus.rsp_zero),  32'(m_zero));
    for (int i = 0; i < NR; i++) begin
      chk("stat_wait_cnt", 32'(stat[i]), STATS ? 32'(m_cnt[i]) : 32'd0);
    end
  endtask

  task automatic set_req(input int i, input bit v, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i] = v;
    bus.req_op[i]    = op;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, ALU_ADD, '0, '0);
    m_valid = 0; m_id = 0; m_result = '0; m_zero = 0; m_ptr = 0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;

    // Reset state; a valid request must not be granted while in reset
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
    cycle();
    chk("reset_ready",  32'(last_ready),     32'd0);
    chk("reset_valid",  32'(bus.rsp_valid),  32'd0);
    chk("reset_result", bus.rsp_result,      32'd0);
    rst = 1'b0;

    // Single request: ADD 5+7
    set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    cycle();
    chk("t1_ready",  32'(last_ready),    32'b001);
    chk("t1_result", bus.rsp_result,     32'd12);
    chk("t1_id",     32'(bus.rsp_id),    32'd0);
    chk("t1_zero",   32'(bus.rsp_zero),  32'd0);
    set_req(0, 1'b0, ALU_ADD, '0, '0);
    cycle();
    chk("t1_drain", 32'(bus.rsp_valid), 32'd0);

    // Contention from a fresh pointer: 0,1,0,1 one per cycle
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 32'd1,  32'd1);
    set_req(1, 1'b1, ALU_SUB, 32'd10, 32'd3);
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("t2_id",     32'(bus.rsp_id),    32'(n % 2));
      chk("t2_result", bus.rsp_result,     (n % 2 == 0) ? 32'd2 : 32'd7);
    end

    // Backpressure: held for 5 cycles, then drain and regrant together
    bus.rsp_ready = 1'b0;
    held = bus.rsp_result;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("t3_ready", 32'(last_ready),  32'd0);
      chk("t3_hold",  bus.rsp_result,   held);
    end
    bus.rsp_ready = 1'b1;
    cycle();
    chk("t3_regrant", 32'(last_ready),   32'b001);
    chk("t3_valid",   32'(bus.rsp_valid), 32'd1);
    set_req(1, 1'b0, ALU_ADD, '0, '0);

    // Arithmetic edges through requester 0
    set_req(0, 1'b1, ALU_SUB, 32'd0, 32'd1);
    cycle(); chk("t4_sub",  bus.rsp_result, 32'hFFFF_FFFF);
    set_req(0, 1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    cycle(); chk("t4_slt",  bus.rsp_result, 32'd1);
    set_req(0, 1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    cycle(); chk("t4_sltu", bus.rsp_result, 32'd0);
    set_req(0, 1'b1, ALU_XOR, 32'h5A5A_1234, 32'h5A5A_1234);
    cycle(); chk("t4_xor",  bus.rsp_result, 32'd0);
    chk("t4_xor_zero", 32'(bus.rsp_zero), 32'd1);
    set_req(0, 1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    cycle(); chk("t4_add_wrap", 32'(bus.rsp_zero), 32'd1);
    set_req(0, 1'b1, alu_op_t'(3'd7), 32'd9, 32'd9);
    cycle(); chk("t4_badop", bus.rsp_result, 32'd0);

    // Reset with a response pending; requester 0 wins the next tie
    set_req(0, 1'b0, ALU_ADD, '0, '0);
    set_req(1, 1'b1, ALU_OR, 32'hF0, 32'h0F);
    rst = 1'b1;
    cycle();
    chk("t5_valid",  32'(bus.rsp_valid), 32'd0);
    chk("t5_result", bus.rsp_result,     32'd0);
    rst = 1'b0;
    set_req(0, 1'b1, ALU_AND, 32'hFF, 32'h3C);
    cycle();
    chk("t5_tie",    32'(last_ready),   32'b001);
    chk("t5_result2", bus.rsp_result,   32'h3C);

    // Stall counters: requester 1 waits behind requester 0, then backpressure
    rst = 1'b1;
    set_req(0, 1'b0, ALU_ADD, '0, '0);
    set_req(1, 1'b0, ALU_ADD, '0, '0);
    cycle();
    rst = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 32'd3, 32'd4);
    set_req(1, 1'b1, ALU_ADD, 32'd5, 32'd6);
    cycle();
    set_req(0, 1'b0, ALU_ADD, '0, '0);
    bus.rsp_ready = 1'b0;
    cycle();
    cycle();
    bus.rsp_ready = 1'b1;
    cycle();
    chk("t6_cnt3", 32'(stat[1]), STATS ? 32'd3 : 32'd0);
    bus.rsp_ready = 1'b0;
    for (int n = 0; n < 20; n++) cycle();
    chk("t6_sat", 32'(stat[1]), STATS ? 32'(CMAX) : 32'd0);

    // Random traffic obeying the requester hold rules
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!bus.req_valid[i] || last_ready[i]) begin
          set_req(i, 1'($urandom_range(0, 1)), alu_op_t'($urandom_range(0, 7)),
                  pick_operand(), pick_operand());
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
